serial_word_deserializer: RTL and testbench

- Upstream stage of the 7-bit combinational encoder/ones-counter pair (Q6 / Q6_2).
- Collects a serial bit stream LSB-first into WIDTH-bit words.
- Presents each completed word on a parallel bus, held stable, with a valid/ready handshake, so the downstream combinational stage always sees a complete, stable `a` vector.
- One-entry output holding register lets the next word be collected while the current one waits.

---
 rtl/serial_word_deserializer_pkg.sv | 18 +
 rtl/deser_bit_counter.sv | 40 ++++
 rtl/serial_word_deserializer.sv | 123 ++++++++++++
 tb/tb_serial_word_deserializer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_word_deserializer_pkg.sv
// Shared types and constants for the serial word deserializer.
// Parity helper is used only when DESER_PARITY_EN is defined.
package serial_word_deserializer_pkg;

  localparam int WIDTH_DEF = 7;
  localparam int CNT_W_DEF = 3;

  typedef enum logic {
    COLLECT = 1'b0,
    STALL   = 1'b1
  } state_e;

  // Bit value that makes the total count of ones in {word, bit} odd.
  function automatic logic odd_parity(input logic [WIDTH_DEF-1:0] word);
    return ~(^word);
  endfunction

endpackage

// File: rtl/deser_bit_counter.sv
// Frame bit counter: counts accepted bits and wraps to 0 after LIMIT.
// tc flags that the next accepted bit completes the frame.
module deser_bit_counter #(
  parameter int CNT_W = 3,
  parameter int LIMIT = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  localparam logic [CNT_W-1:0] LIM = CNT_W'(LIMIT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    tc    = (cnt_q == LIM);
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = tc ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/serial_word_deserializer.sv
// Collects LSB-first serial bits into words behind a one-entry valid/ready holding register.
// Define DESER_PARITY_EN to add a trailing odd-parity bit per frame and the word_perr output.
module serial_word_deserializer
  import serial_word_deserializer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_clr,
  input  logic             bit_valid,
  input  logic             bit_in,
  output logic             bit_ready,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
`ifdef DESER_PARITY_EN
  output logic             word_perr,
`endif
  output logic [CNT_W-1:0] bit_cnt
);

`ifdef DESER_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(FRAME - 1);
  localparam logic [CNT_W-1:0] LAST_M1 = CNT_W'(FRAME - 2);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d, shift_w;
  logic [WIDTH-1:0] word_out_q, word_out_d;
  logic             word_valid_q, word_valid_d;
  logic             accept, complete, cnt_tc, in_last_d;
`ifdef DESER_PARITY_EN
  logic             perr_q, perr_d;
`endif

  deser_bit_counter #(
    .CNT_W (CNT_W),
    .LIMIT (FRAME - 1)
  ) u_bit_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (frame_clr),
    .inc   (accept),
    .cnt   (bit_cnt),
    .tc    (cnt_tc)
  );

  // STALL is registered as "final bit pending and holding register full"; the
  // current word_ready decides whether that actually blocks this cycle.
  always_comb begin
    bit_ready = !((state_q == STALL) && !word_ready);
    accept    = bit_valid && bit_ready && !frame_clr;
    complete  = accept && cnt_tc;

    shift_w = shift_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (bit_cnt == CNT_W'(i)) shift_w[i] = bit_in;
    end

    shift_d = shift_q;
    if (frame_clr || complete) begin
      shift_d = '0;
    end else if (accept) begin
      shift_d = shift_w;
    end

    word_out_d = word_out_q;
`ifdef DESER_PARITY_EN
    perr_d = perr_q;
    if (complete) begin
      word_out_d = shift_q;
      perr_d     = bit_in ^ odd_parity(WIDTH_DEF'(shift_q));
    end
`else
    if (complete) word_out_d = shift_w;
`endif

    word_valid_d = word_valid_q;
    if (complete) begin
      word_valid_d = 1'b1;
    end else if (word_valid_q && word_ready) begin
      word_valid_d = 1'b0;
    end
  end

  always_comb begin
    in_last_d = (accept && (bit_cnt == LAST_M1)) ||
                ((bit_cnt == LAST) && !accept && !frame_clr);
    state_d   = (in_last_d && word_valid_d) ? STALL : COLLECT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= COLLECT;
      shift_q      <= '0;
      word_out_q   <= '0;
      word_valid_q <= 1'b0;
`ifdef DESER_PARITY_EN
      perr_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      word_out_q   <= word_out_d;
      word_valid_q <= word_valid_d;
`ifdef DESER_PARITY_EN
      perr_q       <= perr_d;
`endif
    end
  end

  assign word_out   = word_out_q;
  assign word_valid = word_valid_q;
`ifdef DESER_PARITY_EN
  assign word_perr  = perr_q;
`endif

endmodule

// File: tb/tb_serial_word_deserializer.sv
// Directed plus randomized bench for serial_word_deserializer against a bit-queue model.
// Honors DESER_PARITY_EN the same way the design does.
module tb_serial_word_deserializer;

  localparam int W = 7;
`ifdef DESER_PARITY_EN
  localparam int FR = W + 1;
`else
  localparam int FR = W;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         frame_clr = 1'b0;
  logic         bit_valid = 1'b0;
  logic         bit_in = 1'b0;
  logic         word_ready = 1'b0;
  logic         bit_ready;
  logic [W-1:0] word_out;
  logic         word_valid;
  logic [2:0]   bit_cnt;
`ifdef DESER_PARITY_EN
  logic         word_perr;
`endif

  serial_word_deserializer #(.WIDTH(W), .CNT_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_clr  (frame_clr),
    .bit_valid  (bit_valid),
    .bit_in     (bit_in),
    .bit_ready  (bit_ready),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
`ifdef DESER_PARITY_EN
    .word_perr  (word_perr),
`endif
    .bit_cnt    (bit_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference: partial frame as a bit list, plus a one-deep held word.
  int           m_n;
  logic [W-1:0] m_part, m_word;
  logic         m_valid, m_perr, m_par;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_n = 0; m_part = '0; m_word = '0; m_valid = 1'b0; m_perr = 1'b0; m_par = 1'b0;
  endtask

  function automatic logic model_ready(input logic wr);
    return !((m_n == FR - 1) && m_valid && !wr);
  endfunction

  task automatic model_step(input logic bv, input logic bi, input logic wr, input logic fc);
    logic rdy, cons, load;
    rdy  = model_ready(wr);
    cons = m_valid && wr;
    load = 1'b0;
    if (fc) begin
      m_n = 0; m_part = '0; m_par = 1'b0;
    end else if (bv && rdy) begin
      if (m_n < W) m_part[m_n] = bi;
      m_par = m_par ^ bi;
      m_n++;
      if (m_n == FR) begin
        m_word = m_part;
        m_perr = (m_par == 1'b0);
        load   = 1'b1;
        m_n = 0; m_part = '0; m_par = 1'b0;
      end
    end
    if (load) m_valid = 1'b1;
    else if (cons) m_valid = 1'b0;
  endtask

  task automatic check_outputs();
    chk("word_valid", word_valid, m_valid);
    chk("word_out", word_out, m_word);
    chk("bit_cnt", bit_cnt, m_n);
`ifdef DESER_PARITY_EN
    chk("word_perr", word_perr, m_perr);
`endif
  endtask

  task automatic step(input logic bv, input logic bi, input logic wr, input logic fc);
    @(negedge clk);
    bit_valid = bv; bit_in = bi; word_ready = wr; frame_clr = fc;
    #1;
    chk("bit_ready", bit_ready, model_ready(wr));
    @(posedge clk);
    model_step(bv, bi, wr, fc);
    #1;
    check_outputs();
  endtask

  function automatic logic fbit(input logic [W-1:0] w, input logic p, input int i);
    return (i < W) ? w[i] : p;
  endfunction

  function automatic logic good_par(input logic [W-1:0] w);
    return ~(^w);
  endfunction

  task automatic send_bits(input logic [W-1:0] w, input logic p, input int lo, input int hi,
                           input logic wr);
    for (int i = lo; i < hi; i++) step(1'b1, fbit(w, p, i), wr, 1'b0);
  endtask

  task automatic async_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_word_valid", word_valid, 1'b0);
    chk("rst_word_out", word_out, '0);
    chk("rst_bit_cnt", bit_cnt, '0);
    chk("rst_bit_ready", bit_ready, 1'b1);
    model_reset();
    @(negedge clk);
    bit_valid = 1'b0; frame_clr = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [W-1:0] rw;
    model_reset();
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("init_word_valid", word_valid, 1'b0);
    chk("init_word_out", word_out, '0);
    chk("init_bit_cnt", bit_cnt, '0);
    chk("init_bit_ready", bit_ready, 1'b1);
    @(negedge clk) rst_n = 1'b1;

    // 1,0,1,1,0,0,1 LSB first
    send_bits(7'b1001101, good_par(7'b1001101), 0, FR - 1, 1'b1);
    chk("t1_not_yet_valid", word_valid, 1'b0);
    send_bits(7'b1001101, good_par(7'b1001101), FR - 1, FR, 1'b1);
    chk("t1_word", word_out, 7'b1001101);
    chk("t1_valid", word_valid, 1'b1);
    chk("t1_popcount", $countones(word_out), 4);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // back-pressure: 7F held while 01 stalls on its final bit
    send_bits(7'h7F, good_par(7'h7F), 0, FR, 1'b0);
    send_bits(7'h01, good_par(7'h01), 0, FR - 1, 1'b0);
    chk("t2_cnt_last", bit_cnt, FR - 1);
    step(1'b1, fbit(7'h01, good_par(7'h01), FR - 1), 1'b0, 1'b0);
    step(1'b1, fbit(7'h01, good_par(7'h01), FR - 1), 1'b0, 1'b0);
    chk("t2_hold_7f", word_out, 7'h7F);
    chk("t2_stall_ready", bit_ready, 1'b0);
    step(1'b1, fbit(7'h01, good_par(7'h01), FR - 1), 1'b1, 1'b0);
    chk("t2_second_word", word_out, 7'h01);
    chk("t2_second_valid", word_valid, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // consume and final bit on the same edge
    send_bits(7'h2A, good_par(7'h2A), 0, FR, 1'b0);
    send_bits(7'h55, good_par(7'h55), 0, FR - 1, 1'b0);
    step(1'b1, fbit(7'h55, good_par(7'h55), FR - 1), 1'b1, 1'b0);
    chk("t3_no_bubble", word_valid, 1'b1);
    chk("t3_word", word_out, 7'h55);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // frame_clr drops the partial word and the coincident bit
    send_bits(7'h7C, 1'b1, 0, 4, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("t4_cnt_cleared", bit_cnt, 0);
    send_bits(7'h03, good_par(7'h03), 0, FR, 1'b1);
    chk("t4_word", word_out, 7'h03);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // async reset mid-word
    send_bits(7'h1F, 1'b0, 0, 5, 1'b1);
    async_reset();
    // async reset during stall
    send_bits(7'h33, good_par(7'h33), 0, FR, 1'b0);
    send_bits(7'h4C, good_par(7'h4C), 0, FR, 1'b0);
    async_reset();
    send_bits(7'h66, good_par(7'h66), 0, FR - 1, 1'b1);
    chk("t5_no_word_yet", word_valid, 1'b0);
    send_bits(7'h66, good_par(7'h66), FR - 1, FR, 1'b1);
    chk("t5_word", word_out, 7'h66);
    step(1'b0, 1'b0, 1'b1, 1'b0);

`ifdef DESER_PARITY_EN
    send_bits(7'h01, 1'b0, 0, FR, 1'b1);
    chk("t6_perr_good", word_perr, 1'b0);
    send_bits(7'h01, 1'b1, 0, FR, 1'b1);
    chk("t6_perr_bad", word_perr, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
`endif

    // randomized traffic with bursts of back-pressure
    for (int k = 0; k < 600; k++) begin
      rw = W'($urandom);
      step($urandom_range(0, 3) != 0, rw[0], ((k / 40) % 2 == 0) ? ($urandom_range(0, 3) == 0)
           : ($urandom_range(0, 3) != 0), $urandom_range(0, 40) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
